// File: rtl/mem_bus_if.sv
// MEM-stage memory access unit: alignment check, SPM/bus routing, bus handshake FSM.
// Optional bus-ready watchdog and bus_err port enabled by defining BUS_TIMEOUT_EN.
module mem_bus_if #(
  parameter logic [2:0]  SPM_LOC     = 3'h3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_en,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_out,
  input  logic [31:0] ex_wr_data,
  output logic [31:0] out,
  output logic        miss_align,
  output logic        busy,
  output logic [29:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] spm_rd_data,
  output logic        bus_req_,
  input  logic        bus_grant_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
`ifdef BUS_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_LDW, OP_STW, OP_RSV} op_t;

  state_t      state, state_nx;
  op_t         op;
  logic        is_ld, is_st, acc, misal, spm_hit;
  logic        start, done, tmo;
  logic [31:0] done_data;
  logic [31:0] rd_buf;

  assign op          = op_t'(ex_mem_op);
  assign is_ld       = (op == OP_LDW);
  assign is_st       = (op == OP_STW);
  assign acc         = ex_en & (is_ld | is_st) & ~flush;
  assign misal       = acc & (ex_out[1:0] != 2'b00);
  assign spm_hit     = (ex_out[31:29] == SPM_LOC);
  assign spm_addr    = ex_out[31:2];
  assign spm_wr_data = ex_wr_data;

`ifdef BUS_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYC - 1);
  logic [4:0] cnt;

  assign tmo     = ~reset & (state == ACCESS) & (cnt == TMO_LAST);
  assign bus_err = tmo & bus_rdy_;

  always_ff @(posedge clk) begin
    if (reset || state != ACCESS || state_nx != ACCESS) cnt <= '0;
    else                                                 cnt <= cnt + 5'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Combinational outputs are forced to their idle values while reset is held.
  always_comb begin
    state_nx   = state;
    out        = '0;
    busy       = 1'b0;
    miss_align = 1'b0;
    spm_as_    = 1'b1;
    spm_rw     = 1'b1;
    start      = 1'b0;
    done       = 1'b0;
    done_data  = '0;
    if (!reset) begin
      miss_align = misal;
      case (state)
        IDLE: begin
          if (!acc) begin
            out = ex_out;
          end else if (misal) begin
            out = '0;
          end else if (spm_hit) begin
            spm_as_ = stall;
            spm_rw  = is_ld;
            out     = is_ld ? spm_rd_data : '0;
          end else if (!stall) begin
            busy     = 1'b1;
            start    = 1'b1;
            state_nx = REQ;
          end
        end
        REQ: begin
          busy = 1'b1;
          if (!bus_grant_) state_nx = ACCESS;
        end
        ACCESS: begin
          if (!bus_rdy_ || tmo) begin
            done      = 1'b1;
            done_data = (!bus_rdy_ && bus_rw) ? bus_rd_data : '0;
            out       = done_data;
            state_nx  = stall ? STALL : IDLE;
          end else begin
            busy = 1'b1;
          end
        end
        STALL: begin
          out = rd_buf;
          if (!stall) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      state <= state_nx;
      if (start) bus_req_ <= 1'b0;
      if (state == REQ && !bus_grant_) begin
        bus_as_     <= 1'b0;
        bus_addr    <= ex_out[31:2];
        bus_rw      <= is_ld;
        bus_wr_data <= ex_wr_data;
      end else begin
        bus_as_ <= 1'b1;
      end
      if (done) begin
        rd_buf   <= done_data;
        bus_req_ <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- MEM-stage memory access unit. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- It takes the EX-stage ALU result, the memory op and the store data. It checks word alignment and routes the access either to the scratch-pad memory (SPM, single cycle) or to the shared bus (request/grant handshake).
- It produces the `out` and `miss_align` values consumed by the MEM/WB register.
- It raises `busy` while a bus transaction is outstanding so the pipeline stalls.

Parameters:
- SPM_LOC, default 3'h3: value of byte-address bits [31:29] that selects the SPM.
- TIMEOUT_CYC, default 16: bus-ready watchdog limit in cycles. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  global pipeline stall; excludes this block's busy
- flush  in  1  pipeline flush
- ex_en  in  1  EX/MEM entry valid
- ex_mem_op  in  2  0=NOP, 1=LDW, 2=STW, 3=reserved (treated as NOP)
- ex_out  in  32  ALU result; this is the byte address for LDW/STW
- ex_wr_data  in  32  store data
- out  out  32  result to MEM/WB register
- miss_align  out  1  misaligned access detected
- busy  out  1  stall request
- spm_addr  out  30  SPM word address
- spm_as_  out  1  SPM strobe, active low
- spm_rw  out  1  1=read, 0=write
- spm_wr_data  out  32  SPM write data
- spm_rd_data  in  32  SPM read data, valid in the same cycle
- bus_req_  out  1  bus request, active low
- bus_grant_  in  1  bus grant, active low
- bus_addr  out  30  bus word address
- bus_as_  out  1  bus address strobe, active low
- bus_rw  out  1  1=read, 0=write
- bus_wr_data  out  32  bus write data
- bus_rd_data  in  32  bus read data
- bus_rdy_  in  1  bus ready, active low

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_buf=0.
- Combinational outputs at reset: out=0, busy=0, miss_align=0, spm_as_=1.
- Access condition: acc = ex_en & (op==LDW | op==STW) & ~flush.
- miss_align = acc & (ex_out[1:0]!=0). This is combinational. A misaligned access issues no SPM or bus access, and out=0.
- Word address = ex_out[31:2]. spm_addr and spm_wr_data always follow ex_out[31:2] and ex_wr_data.
- Non-access, IDLE: out=ex_out (pass-through).
- IDLE, aligned acc, SPM hit (ex_out[31:29]==SPM_LOC), stall=0:
  - spm_as_=0, spm_rw=(op==LDW).
  - out=spm_rd_data for LDW, 0 for STW.
  - busy=0. No state change.
- IDLE, aligned acc, non-SPM, stall=0: busy=1, register bus_req_=0, next state REQ.
- REQ: busy=1. When bus_grant_=0, register bus_as_=0, bus_addr, bus_rw=(op==LDW) and bus_wr_data; next state ACCESS.
- ACCESS:
  - bus_as_ returns to 1 after one cycle. busy=1 until bus_rdy_=0.
  - On the bus_rdy_=0 cycle: busy=0, out=bus_rd_data (LDW) or 0 (STW). Register rd_buf=that value and bus_req_=1.
  - Next state: STALL if stall=1, else IDLE.
- STALL: out=rd_buf, busy=0. Return to IDLE when stall=0.
- Latency:
  - SPM access: 0 extra cycles.
  - Bus access, minimum: grant in REQ and ready one cycle after the strobe gives busy=1 for 3 cycles.
- flush does not abort REQ/ACCESS; the bus transaction always completes. flush only suppresses new accesses in IDLE.
- stall=1 in IDLE suppresses initiation of a bus access; the SPM strobe is still gated by ~stall.
- bus_grant_ deasserted during ACCESS is ignored.
- Reset mid-transaction returns all outputs to reset values on that edge. A lost transaction is acceptable.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A 5-bit counter starts in ACCESS and clears on leaving ACCESS.
  - If it reaches TIMEOUT_CYC without bus_rdy_=0, the transaction is terminated as if ready arrived with data 0: busy=0, out=0, bus_req_=1.
  - Output bus_err (1 bit) pulses for that one cycle.
- BUS_TIMEOUT_EN undefined: no counter and no bus_err port. ACCESS waits indefinitely.

Test Plan:
- ex_en=1, LDW, ex_out=32'h6000_0010 (SPM), spm_rd_data=32'hDEAD_BEEF -> same cycle spm_as_=0, spm_addr=30'h1800_0004, out=32'hDEAD_BEEF, busy=0.
- LDW, ex_out=32'h0000_0102 -> miss_align=1, out=0, spm_as_=1, bus_req_ stays 1.
- STW to 32'h0000_0100 with data 32'h1234_5678, grant after 2 cycles, ready 1 cycle after strobe -> bus_addr=30'h40, bus_rw=0, bus_wr_data=32'h1234_5678, busy high for 4 cycles, out=0.
- LDW to 32'h0000_0200, ready with bus_rd_data=32'hA5A5_A5A5 while stall=1 for 3 more cycles -> state STALL, out holds 32'hA5A5_A5A5 and busy=0 until stall drops.
- flush=1 in IDLE with a valid non-SPM LDW -> bus_req_ stays 1, busy=0. flush asserted during ACCESS -> transaction still completes on bus_rdy_.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=16, bus_rdy_ held 1 -> after 16 ACCESS cycles bus_err=1 for 1 cycle, out=0, busy=0, state IDLE.
